hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Control-side counterpart of the decode/execute pipeline register in the RV32I 5-stage pipeline.
- Consumes the execute-stage register addresses (Rs1_e, Rs2_e, Rd_e) together with the decode-stage sources.
- Drives the Clear/stall controls back into the F/D and D/E registers, and the execute-stage operand-forwarding selects.
- Keeps its own shadow pipeline of destination tags for the M and W stages, plus saturating hazard-event counters.

Parameters:
- CNT_W, 16, width of each saturating event counter.

Ports:
- Clk  input  1  rising-edge clock
- Clear_n  input  1  asynchronous active-low reset
- Rs1_d  input  5  decode-stage source 1 address
- Rs2_d  input  5  decode-stage source 2 address
- Rs1_e  input  5  execute-stage source 1 address
- Rs2_e  input  5  execute-stage source 2 address
- Rd_e  input  5  execute-stage destination address
- RegWrite_e  input  1  execute-stage instruction writes Rd
- Load_e  input  1  execute-stage instruction is a load
- PcSrc_e  input  1  taken branch or jump resolved in E
- Forward_a_e  output  2  operand A select: 00 regfile, 10 from M, 01 from W
- Forward_b_e  output  2  operand B select, same encoding
- Stall_f  output  1  hold PC
- Stall_d  output  1  hold F/D register
- Flush_d  output  1  clear F/D register
- Flush_e  output  1  clear D/E register (drives its Clear)
- Rd_m  output  5  shadow M-stage destination
- Rd_w  output  5  shadow W-stage destination
- Stall_cnt  output  CNT_W  load-use stall cycles
- Flush_cnt  output  CNT_W  branch flush events

Behaviour:
Reset (Clear_n low, asynchronous):
- All shadow registers clear: Rd_m, Rd_w, RegWrite_m, RegWrite_w, Load_m.
- Counters clear to 0.
- Outputs then take these values: Forward selects 00, all stall/flush outputs 0.

Shadow pipeline (every rising Clk, never stalled):
- Rd_m <= Rd_e; RegWrite_m <= RegWrite_e; Load_m <= Load_e.
- Rd_w <= Rd_m; RegWrite_w <= RegWrite_m.
- Flush_e only bubbles the D/E register. The E-stage instruction present that cycle still advances into M.

Forwarding (combinational from current state and inputs):
- Forward_a_e = 10 if RegWrite_m, Rd_m != 0 and Rd_m == Rs1_e.
- Otherwise 01 if RegWrite_w, Rd_w != 0 and Rd_w == Rs1_e.
- Otherwise 00.
- Forward_b_e is identical using Rs2_e.
- M-stage match has priority over W.
- x0 is never forwarded.

Load-use hazard:
- lwstall = Load_e AND Rd_e != 0 AND (Rd_e == Rs1_d OR Rd_e == Rs2_d).
- When asserted: Stall_f = Stall_d = 1 and Flush_e = 1, for exactly one cycle.
- Next cycle the load sits in M and the consumer in E, so lwstall drops. The following cycle the W-stage forward (01) supplies the load data.

Control hazard:
- PcSrc_e = 1 gives Flush_d = 1 and Flush_e = 1 for one cycle.

Simultaneous PcSrc_e and lwstall:
- The branch wins: Flush_d = 1, Flush_e = 1, Stall_f = Stall_d = 0.
- Neither counter records a stall; only Flush_cnt increments.

Counters:
- Stall_cnt increments on each clock where Stall_d = 1.
- Flush_cnt increments on each clock where PcSrc_e = 1.
- Both saturate at 2^CNT_W - 1 with no wrap.

Reset mid-operation:
- Pending forwards and stalls disappear immediately, since outputs are combinational from state that is now clear.

Test Plan:
1. Reset mid-stall: hold Load_e = 1 with a matching Rs1_d, then assert Clear_n = 0 -> Rd_m = Rd_w = 0 and Stall_cnt = 0 immediately. After release with inputs idle -> all controls 0.
2. Back-to-back ALU forward: cycle n has Rd_e = 5, RegWrite_e = 1. At n+1, Rs1_e = 5 -> Forward_a_e = 10. At n+2, Rs2_e = 5 with no newer writer -> Forward_b_e = 01.
3. x0 and priority: RegWrite with Rd = 0 followed by Rs1_e = 0 -> Forward_a_e = 00. Two consecutive writers to x7, then Rs1_e = 7 -> 10 (M beats W).
4. Load-use: Load_e = 1, Rd_e = 3, Rs2_d = 3 -> one cycle of Stall_f = Stall_d = Flush_e = 1 and Stall_cnt 0 -> 1. Two cycles later, Rs2_e = 3 -> Forward_b_e = 01.
5. Branch beats load-use: PcSrc_e = 1 together with the load-use pattern above -> Flush_d = Flush_e = 1, Stall_f = Stall_d = 0, Flush_cnt increments, Stall_cnt unchanged.
6. Saturation: CNT_W = 4 with 20 consecutive branch flushes -> Flush_cnt sticks at 15.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the RV32I 5-stage pipeline.
// Tracks M/W destination tags and counts load-use stalls and branch flushes.
module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Clear_n,
    input  logic [4:0]       Rs1_d,
    input  logic [4:0]       Rs2_d,
    input  logic [4:0]       Rs1_e,
    input  logic [4:0]       Rs2_e,
    input  logic [4:0]       Rd_e,
    input  logic             RegWrite_e,
    input  logic             Load_e,
    input  logic             PcSrc_e,
    output logic [1:0]       Forward_a_e,
    output logic [1:0]       Forward_b_e,
    output logic             Stall_f,
    output logic             Stall_d,
    output logic             Flush_d,
    output logic             Flush_e,
    output logic [4:0]       Rd_m,
    output logic [4:0]       Rd_w,
    output logic [CNT_W-1:0] Stall_cnt,
    output logic [CNT_W-1:0] Flush_cnt
);

    logic reg_write_m;
    logic reg_write_w;
    logic load_m;
    logic lwstall;
    logic stall;
    logic unused_load_m;

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            Rd_m        <= '0;
            Rd_w        <= '0;
            reg_write_m <= 1'b0;
            reg_write_w <= 1'b0;
            load_m      <= 1'b0;
        end else begin
            Rd_m        <= Rd_e;
            reg_write_m <= RegWrite_e;
            load_m      <= Load_e;
            Rd_w        <= Rd_m;
            reg_write_w <= reg_write_m;
        end
    end

    assign unused_load_m = load_m;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_write_m && Rd_m != 5'd0 && Rd_m == rs)
            return 2'b10;
        else if (reg_write_w && Rd_w != 5'd0 && Rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        Forward_a_e = fwd_sel(Rs1_e);
        Forward_b_e = fwd_sel(Rs2_e);
    end

    assign lwstall = Load_e && (Rd_e != 5'd0) &&
                     ((Rd_e == Rs1_d) || (Rd_e == Rs2_d));

    // A taken branch squashes the load-use consumer, so it wins over the stall
    always_comb begin
        stall   = 1'b0;
        Stall_f = 1'b0;
        Stall_d = 1'b0;
        Flush_d = 1'b0;
        Flush_e = 1'b0;
        if (Clear_n) begin
            stall   = lwstall && !PcSrc_e;
            Stall_f = stall;
            Stall_d = stall;
            Flush_d = PcSrc_e;
            Flush_e = PcSrc_e || lwstall;
        end
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            Stall_cnt <= '0;
            Flush_cnt <= '0;
        end else begin
            if (Stall_d && Stall_cnt != '1)
                Stall_cnt <= Stall_cnt + 1'b1;
            if (PcSrc_e && Flush_cnt != '1)
                Flush_cnt <= Flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit.
// A second CNT_W=4 instance shares the stimulus to exercise saturation.
module tb_hazard_forward_unit;

    logic        Clk;
    logic        Clear_n;
    logic [4:0]  Rs1_d, Rs2_d, Rs1_e, Rs2_e, Rd_e;
    logic        RegWrite_e, Load_e, PcSrc_e;
    logic [1:0]  Forward_a_e, Forward_b_e;
    logic        Stall_f, Stall_d, Flush_d, Flush_e;
    logic [4:0]  Rd_m, Rd_w;
    logic [15:0] Stall_cnt, Flush_cnt;

    logic [1:0]  s_fa, s_fb;
    logic        s_sf, s_sd, s_fd, s_fe;
    logic [4:0]  s_rdm, s_rdw;
    logic [3:0]  s_scnt, s_fcnt;

    int checks = 0;
    int errors = 0;

    hazard_forward_unit #(.CNT_W(16)) u_dut (
        .Clk(Clk), .Clear_n(Clear_n),
        .Rs1_d(Rs1_d), .Rs2_d(Rs2_d),
        .Rs1_e(Rs1_e), .Rs2_e(Rs2_e), .Rd_e(Rd_e),
        .RegWrite_e(RegWrite_e), .Load_e(Load_e), .PcSrc_e(PcSrc_e),
        .Forward_a_e(Forward_a_e), .Forward_b_e(Forward_b_e),
        .Stall_f(Stall_f), .Stall_d(Stall_d),
        .Flush_d(Flush_d), .Flush_e(Flush_e),
        .Rd_m(Rd_m), .Rd_w(Rd_w),
        .Stall_cnt(Stall_cnt), .Flush_cnt(Flush_cnt)
    );

    hazard_forward_unit #(.CNT_W(4)) u_sat (
        .Clk(Clk), .Clear_n(Clear_n),
        .Rs1_d(Rs1_d), .Rs2_d(Rs2_d),
        .Rs1_e(Rs1_e), .Rs2_e(Rs2_e), .Rd_e(Rd_e),
        .RegWrite_e(RegWrite_e), .Load_e(Load_e), .PcSrc_e(PcSrc_e),
        .Forward_a_e(s_fa), .Forward_b_e(s_fb),
        .Stall_f(s_sf), .Stall_d(s_sd),
        .Flush_d(s_fd), .Flush_e(s_fe),
        .Rd_m(s_rdm), .Rd_w(s_rdw),
        .Stall_cnt(s_scnt), .Flush_cnt(s_fcnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Rs1_d = 0; Rs2_d = 0; Rs1_e = 0; Rs2_e = 0; Rd_e = 0;
        RegWrite_e = 0; Load_e = 0; PcSrc_e = 0;
    endtask

    // Advance one clock; inputs are then changed 1ns after the edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ctrl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, Stall_f, Stall_d, Flush_d, Flush_e}, {28'd0, exp});
    endtask

    initial begin
        idle();
        Clear_n = 1'b0;
        #12;
        Clear_n = 1'b1;
        tick();

        // 1: reset in the middle of a load-use stall
        Load_e = 1; RegWrite_e = 1; Rd_e = 3; Rs1_d = 3;
        tick();
        tick();
        check("pre_rst_stall_cnt", Stall_cnt, 2);
        check("pre_rst_rd_m", Rd_m, 3);
        #2;
        Clear_n = 1'b0;
        #1;
        check("rst_rd_m", Rd_m, 0);
        check("rst_rd_w", Rd_w, 0);
        check("rst_stall_cnt", Stall_cnt, 0);
        ctrl("rst_ctrl", 4'b0000);
        #3;
        idle();
        Clear_n = 1'b1;
        tick();
        #1;
        ctrl("post_rst_ctrl", 4'b0000);
        check("post_rst_fa", Forward_a_e, 0);
        check("post_rst_fb", Forward_b_e, 0);

        // 2: back-to-back ALU forwarding, M then W
        Rd_e = 5; RegWrite_e = 1;
        tick();
        idle();
        Rs1_e = 5;
        #1;
        check("alu_fwd_a_m", Forward_a_e, 2'b10);
        tick();
        idle();
        Rs2_e = 5;
        #1;
        check("alu_fwd_b_w", Forward_b_e, 2'b01);
        check("alu_fwd_a_none", Forward_a_e, 2'b00);

        // 3: x0 is never forwarded; M beats W
        tick();
        Rd_e = 0; RegWrite_e = 1;
        tick();
        idle();
        #1;
        check("x0_fwd_a", Forward_a_e, 2'b00);
        Rd_e = 7; RegWrite_e = 1;
        tick();
        tick();
        idle();
        Rs1_e = 7;
        #1;
        check("prio_rd_m", Rd_m, 7);
        check("prio_rd_w", Rd_w, 7);
        check("prio_fwd_a", Forward_a_e, 2'b10);
        tick();
        tick();
        idle();
        #1;

        // 4: load-use stall for one cycle, then W forward
        Load_e = 1; RegWrite_e = 1; Rd_e = 3; Rs2_d = 3;
        #1;
        ctrl("lw_ctrl", 4'b1101);
        check("lw_cnt_before", Stall_cnt, 0);
        tick();
        idle();
        #1;
        ctrl("lw_bubble_ctrl", 4'b0000);
        check("lw_cnt_after", Stall_cnt, 1);
        tick();
        idle();
        Rs2_e = 3;
        #1;
        check("lw_fwd_b_w", Forward_b_e, 2'b01);
        tick();
        idle();

        // 5: branch beats load-use
        Load_e = 1; RegWrite_e = 1; Rd_e = 3; Rs2_d = 3; PcSrc_e = 1;
        #1;
        ctrl("br_lw_ctrl", 4'b0011);
        tick();
        idle();
        #1;
        check("br_flush_cnt", Flush_cnt, 1);
        check("br_stall_cnt", Stall_cnt, 1);

        // 6: 20 more branch flushes saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            PcSrc_e = 1;
            tick();
        end
        idle();
        #1;
        check("sat_flush_cnt4", s_fcnt, 15);
        check("wide_flush_cnt", Flush_cnt, 21);
        check("sat_stall_cnt4", s_scnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
